// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between a truth-table checker and whoever feeds it.
// The master side applies (vec, y) pairs and start; the slave side reports status.
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    localparam int DEPTH = 1 << N_IN;

    logic             start;
    logic             vec_valid;
    logic [N_IN-1:0]  vec;
    logic             y;

    logic             busy;
    logic             done;
    logic             pass;
    logic             conflict;
    logic [N_IN-1:0]  fail_idx;
    logic [DEPTH-1:0] captured;

    modport master (
        output start, vec_valid, vec, y,
        input  busy, done, pass, conflict, fail_idx, captured
    );

    modport slave (
        input  start, vec_valid, vec, y,
        output busy, done, pass, conflict, fail_idx, captured
    );
endinterface

// File: rtl/truth_table_checker.sv
// Captures a DUT's responses for every input code, then scans the captured
// table against EXPECTED one index per cycle and reports pass / first failure.
module truth_table_checker #(
    parameter int                    N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'hE8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_checker_if.slave bus
);
    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] seen;
    logic [DEPTH-1:0] seen_upd;
    logic [DEPTH-1:0] captured;
    logic             conflict;
    logic             mismatch;
    logic [N_IN-1:0]  fail_idx;
    logic [N_IN-1:0]  scan_idx;
    logic             clear;
    logic             accept;
    logic             last_scan;

    // start is honoured everywhere except during the scan; it beats vec_valid.
    always_comb begin
        clear     = bus.start && (state != COMPARE);
        accept    = (state == COLLECT) && bus.vec_valid && !bus.start;
        last_scan = &scan_idx;
        seen_upd  = seen;
        if (accept) begin
            seen_upd[bus.vec] = 1'b1;
        end

        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (bus.start)                 state_nxt = COLLECT;
                else if (accept && &seen_upd)  state_nxt = COMPARE;
            end
            COMPARE: begin
                if (last_scan) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) state_nxt = COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            seen     <= '0;
            captured <= '0;
            conflict <= 1'b0;
            mismatch <= 1'b0;
            fail_idx <= '0;
            scan_idx <= '0;
        end else begin
            if (accept) begin
                if (seen[bus.vec] && (captured[bus.vec] != bus.y)) begin
                    conflict <= 1'b1;
                end
                captured[bus.vec] <= bus.y;
                seen              <= seen_upd;
            end
            // scan_idx wraps back to 0 after the last index, ready for the next run.
            if (state == COMPARE) begin
                if (!mismatch && (captured[scan_idx] != EXPECTED[scan_idx])) begin
                    fail_idx <= scan_idx;
                    mismatch <= 1'b1;
                end
                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

    assign bus.busy     = (state == COLLECT) || (state == COMPARE);
    assign bus.done     = (state == DONE);
    assign bus.pass     = (state == DONE) && !mismatch && !conflict;
    assign bus.conflict = conflict;
    assign bus.fail_idx = fail_idx;
    assign bus.captured = captured;
endmodule
